circular_shift_engine: RTL
==========================

CIRCULAR_SHIFT_ENGINE -- requirements
Module: circular_shift_engine

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, data width in bits; power of two, >= 2.
REQ-002 SHALL provide parameter AMT_W, default 3, rotate-amount width; must equal log2(WIDTH).
REQ-003 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL provide port in_valid  input  1  request present.
REQ-006 SHALL provide port in_ready  output  1  engine can accept a request.
REQ-007 SHALL provide port in_data  input  WIDTH  word to rotate.
REQ-008 SHALL provide port in_amt  input  AMT_W  rotate distance, 0..WIDTH-1.
REQ-009 SHALL provide port in_dir  input  1  0 = rotate left (MSB wraps to LSB), 1 = rotate right (LSB wraps to MSB).
REQ-010 SHALL provide port out_valid  output  1  result available.
REQ-011 SHALL provide port out_ready  input  1  consumer accepts result.
REQ-012 SHALL provide port out_data  output  WIDTH  rotated word.
REQ-013 SHALL provide port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-015 IDLE: in_ready=1; on in_valid=1, capture in_data, in_amt and in_dir at the same edge (accept edge E0).
REQ-016 From IDLE on accept: amt=0 -> DONE; amt>0 -> SHIFT with internal counter loaded with amt.
REQ-017 SHIFT: each edge rotate the held word by exactly 1 bit in the captured direction and decrement the counter; at the edge applying the last rotation, go to DONE.
REQ-018 Latency (iterative build): out_valid high immediately after edge E0+amt; amt=0 gives out_valid after E0.
REQ-019 DONE: out_valid=1 and out_data=rotated word; on out_ready=1, go to IDLE at that edge.
REQ-020 out_data and out_valid SHALL remain stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-021 in_ready SHALL be 0 in SHIFT and DONE; in_valid in those states is ignored and nothing is captured.
REQ-022 No overlap: the DONE->IDLE handshake edge SHALL NOT also accept a new request; the earliest next accept is the following edge.
REQ-023 out_valid SHALL be 0 in IDLE and SHIFT; out_data SHALL hold its last value outside DONE.
REQ-024 Rotation SHALL be lossless modulo WIDTH; no bits are dropped or zero-filled.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, out_valid=0, out_data=0, counter=0 and busy=0; in_ready=1 from the next cycle.
REQ-026 rst asserted mid-SHIFT or mid-DONE SHALL discard the operation; no result is ever presented for it.
REQ-027 rst SHALL take priority over in_valid and out_ready at the same edge.

Configuration
REQ-028 Macro CSE_ONESHOT_EN SHALL select the rotate implementation.
REQ-029 CSE_ONESHOT_EN defined: full barrel rotation by amt at the accept edge; FSM goes IDLE->DONE directly; SHIFT is never entered; out_valid high after E0 for every amt.
REQ-030 CSE_ONESHOT_EN undefined: iterative behaviour of REQ-016..REQ-018.
REQ-031 Handshake, stall and reset behaviour SHALL be identical in both builds; only latency differs.

Verification (WIDTH=8 unless stated; out_ready=1 unless stated)
REQ-032 Left 1 vectors: in_data 8'h01 -> 8'h02; 8'h80 -> 8'h01; 8'hF0 -> 8'hE1; each out_valid exactly 1 cycle after accept.
REQ-033 Right 3 on 8'hB4 -> 8'h96 with out_valid after E0+3 (iterative) or E0 (CSE_ONESHOT_EN); amt=0 on 8'h5A -> 8'h5A after E0.
REQ-034 Back-pressure: 8'h3C left 2, out_ready=0 for 5 cycles -> out_data=8'hF0 stable and out_valid=1 throughout, in_ready=0, in_valid pulses ignored; result consumed when out_ready=1.
REQ-035 Reset mid-SHIFT: 8'h81 left 5, rst at E0+2 -> out_valid never rises, out_data=8'h00, in_ready=1 next cycle; the next request 8'h81 left 1 -> 8'h03.
REQ-036 WIDTH=16, AMT_W=4: 16'h0001 left 15 -> 16'h8000 after E0+15; 16'h8000 right 15 -> 16'h0001.
REQ-037 Back-to-back: two requests with in_valid held high -> second accepted exactly one edge after the first handshake edge, never on it.

Source files
------------

// File: rtl/circular_shift_engine_if.sv
// ---------------------------------------------------------------------------
// circular_shift_engine_if
// Request/result bundle for circular_shift_engine.
//   in_valid/in_ready/in_data/in_amt/in_dir : request channel (master -> engine)
//   out_valid/out_ready/out_data            : result channel  (engine -> master)
//   busy                                    : engine status (state not IDLE)
// Modports: master = requester/consumer side, slave = engine side.
// ---------------------------------------------------------------------------
interface circular_shift_engine_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic             in_dir;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    modport master (
        output in_valid, in_data, in_amt, in_dir, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_dir, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/circular_shift_engine.sv
// ---------------------------------------------------------------------------
// circular_shift_engine
// Rotates a WIDTH-bit word left (in_dir=0) or right (in_dir=1) by in_amt
// positions behind a valid/ready request channel and a valid/ready result
// channel. One request is processed at a time (IDLE -> [SHIFT] -> DONE).
//
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : circular_shift_engine_if.slave (request, result, busy)
//
// Build option:
//   CSE_ONESHOT_EN defined   : barrel rotate at the accept edge, IDLE->DONE.
//   CSE_ONESHOT_EN undefined : one bit per cycle in SHIFT, result after
//                              accept edge + amt.
// All outputs are registered.
// ---------------------------------------------------------------------------
module circular_shift_engine #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    circular_shift_engine_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q,     state_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q,  in_ready_d;
    logic             busy_q,      busy_d;

`ifndef CSE_ONESHOT_EN
    logic [WIDTH-1:0] word_q, word_d;
    logic [AMT_W-1:0] cnt_q,  cnt_d;
    logic             dir_q,  dir_d;

    // Single-position rotation; the wrapped bit re-enters at the far end.
    function automatic logic [WIDTH-1:0] rot1(input logic [WIDTH-1:0] w,
                                              input logic             dir);
        if (dir) begin
            return {w[0], w[WIDTH-1:1]};
        end
        return {w[WIDTH-2:0], w[WIDTH-1]};
    endfunction
`else
    // Full rotation: shift a doubled copy so the wrapped bits come along.
    function automatic logic [WIDTH-1:0] rot_n(input logic [WIDTH-1:0] w,
                                               input logic [AMT_W-1:0] amt,
                                               input logic             dir);
        logic [2*WIDTH-1:0] dbl;
        dbl = {w, w};
        if (dir) begin
            dbl = dbl >> amt;
            return dbl[WIDTH-1:0];
        end
        dbl = dbl << amt;
        return dbl[2*WIDTH-1:WIDTH];
    endfunction
`endif

    // Next-state and datapath.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
`ifndef CSE_ONESHOT_EN
        word_d     = word_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
`ifdef CSE_ONESHOT_EN
                    out_data_d = rot_n(bus.in_data, bus.in_amt, bus.in_dir);
                    state_d    = DONE;
`else
                    word_d = bus.in_data;
                    dir_d  = bus.in_dir;
                    cnt_d  = bus.in_amt;
                    if (bus.in_amt == '0) begin
                        out_data_d = bus.in_data;
                        state_d    = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
`endif
                end
            end
`ifndef CSE_ONESHOT_EN
            SHIFT: begin
                word_d = rot1(word_q, dir_q);
                cnt_d  = cnt_q - AMT_W'(1);
                // Edge applying the final rotation also publishes the result.
                if (cnt_q == AMT_W'(1)) begin
                    out_data_d = word_d;
                    state_d    = DONE;
                end
            end
`endif
            DONE: begin
                // No new accept on this edge: IDLE is entered first.
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    // State and output registers; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
`ifndef CSE_ONESHOT_EN
            word_q      <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
`ifndef CSE_ONESHOT_EN
            word_q      <= word_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
`endif
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;

endmodule
